// File: rtl/multicycle_controller_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_pkg
// Shared constants for the multi-cycle LEGv8 control FSM. It holds the state
// encodings, the opcode patterns with their don't-care masks, the ALU operand
// and operation encodings, the error codes, and the instruction class type
// produced by the opcode decoder.
// -----------------------------------------------------------------------------
package multicycle_pkg;

  // FSM state encodings. These are also the values presented on state_out.
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC_R = 4'd2;
  localparam logic [3:0] S_WB_R   = 4'd3;
  localparam logic [3:0] S_ADDR   = 4'd4;
  localparam logic [3:0] S_MEM_RD = 4'd5;
  localparam logic [3:0] S_WB_MEM = 4'd6;
  localparam logic [3:0] S_MEM_WR = 4'd7;
  localparam logic [3:0] S_CBZ    = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_HALT   = 4'd10;

  // Opcode patterns (instruction bits [31:21]).
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_HLT  = 11'b11010100010;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_B    = 11'b00010100000;

  // Mask bits set to 1 are compared; the rest belong to the immediate field.
  localparam logic [10:0] MASK_FULL = 11'b11111111111;
  localparam logic [10:0] MASK_CBZ  = 11'b11111111000;
  localparam logic [10:0] MASK_B    = 11'b11111100000;

  // ALU operand B select.
  localparam logic [1:0] ALUB_REG     = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  // ALU operation select.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  // Halt reasons.
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_LDUR    = 3'd1,
    CLS_STUR    = 3'd2,
    CLS_CBZ     = 3'd3,
    CLS_B       = 3'd4,
    CLS_HLT     = 3'd5,
    CLS_ILLEGAL = 3'd6
  } instr_class_e;

  // True when the opcode equals the pattern on every bit selected by the mask.
  function automatic logic op_match(input logic [10:0] op,
                                    input logic [10:0] pat,
                                    input logic [10:0] mask);
    return ((op & mask) == (pat & mask));
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if
// Bundle of the signals between the control FSM and the datapath.
//   master : the controller (takes opcode/zero/mem_ready, drives controls)
//   slave  : the datapath / environment view of the same signals
// Parameter CNT_W sets the retired-instruction counter width.
// -----------------------------------------------------------------------------
interface multicycle_controller_if #(parameter int CNT_W = 32);

  logic [10:0]      opcode;
  logic             zero;
  logic             mem_ready;

  logic             ir_write;
  logic             pc_write;
  logic             pc_src;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic             reg2loc;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             mem_to_reg;
  logic             halted;
  logic [1:0]       error_code;
  logic [CNT_W-1:0] retired_count;
  logic [3:0]       state_out;

  modport master (
    input  opcode, zero, mem_ready,
    output ir_write, pc_write, pc_src, iord, mem_read, mem_write, reg_write,
           reg2loc, alu_src_a, alu_src_b, alu_op, mem_to_reg, halted,
           error_code, retired_count, state_out
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  ir_write, pc_write, pc_src, iord, mem_read, mem_write, reg_write,
           reg2loc, alu_src_a, alu_src_b, alu_op, mem_to_reg, halted,
           error_code, retired_count, state_out
  );

endinterface

// File: rtl/multicycle_controller_decode.sv
// -----------------------------------------------------------------------------
// legv8_opcode_decode
// Combinational classification of instruction bits [31:21].
//   opcode_i : instruction register bits [31:21]
//   class_o  : R, LDUR, STUR, CBZ, B, HLT or ILLEGAL
// -----------------------------------------------------------------------------
module legv8_opcode_decode
  import multicycle_pkg::*;
(
  input  logic [10:0]  opcode_i,
  output instr_class_e class_o
);

  // Opcode to instruction class; anything unrecognised is illegal.
  always_comb begin
    class_o = CLS_ILLEGAL;
    if (op_match(opcode_i, OP_ADD, MASK_FULL) || op_match(opcode_i, OP_SUB, MASK_FULL) ||
        op_match(opcode_i, OP_AND, MASK_FULL) || op_match(opcode_i, OP_ORR, MASK_FULL)) begin
      class_o = CLS_R;
    end else if (op_match(opcode_i, OP_LDUR, MASK_FULL)) begin
      class_o = CLS_LDUR;
    end else if (op_match(opcode_i, OP_STUR, MASK_FULL)) begin
      class_o = CLS_STUR;
    end else if (op_match(opcode_i, OP_CBZ, MASK_CBZ)) begin
      class_o = CLS_CBZ;
    end else if (op_match(opcode_i, OP_B, MASK_B)) begin
      class_o = CLS_B;
    end else if (op_match(opcode_i, OP_HLT, MASK_FULL)) begin
      class_o = CLS_HLT;
    end else begin
      class_o = CLS_ILLEGAL;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Control FSM for a multi-cycle LEGv8 datapath with a unified memory that
// answers through a mem_ready handshake guarded by a timeout.
//   clock : rising-edge system clock
//   reset : asynchronous active-high reset
//   bus   : master side of multicycle_controller_if (opcode/zero/mem_ready in,
//           datapath controls, halted, error_code, retired_count and
//           state_out out)
// Parameters: MEM_TIMEOUT (>= 1) wait cycles allowed per memory access,
//             CNT_W retired-instruction counter width.
// -----------------------------------------------------------------------------
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  // The counter only needs to reach MEM_TIMEOUT-1: the next miss halts.
  localparam int               TMO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  logic [3:0]       state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             retire_s;
  logic             mem_expire_s;
  instr_class_e     cls_s;

  logic       ir_write_s, pc_write_s, pc_src_s, iord_s, mem_read_s, mem_write_s;
  logic       reg_write_s, reg2loc_s, alu_src_a_s, mem_to_reg_s, halted_s;
  logic [1:0] alu_src_b_s, alu_op_s;

  legv8_opcode_decode u_decode (
    .opcode_i (bus.opcode),
    .class_o  (cls_s)
  );

  // A waiting access gives up once it has already missed MEM_TIMEOUT-1 cycles.
  assign mem_expire_s = !bus.mem_ready && (tmo_q == TMO_LAST);

  // Next state, timeout counter, halt reason and retire strobe.
  always_comb begin
    state_d  = state_q;
    tmo_d    = '0;          // any state change clears the wait counter
    err_d    = err_q;
    retire_s = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end else if (mem_expire_s) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DECODE: begin
        case (cls_s)
          CLS_R:    state_d = S_EXEC_R;
          CLS_LDUR: state_d = S_ADDR;
          CLS_STUR: state_d = S_ADDR;
          CLS_CBZ:  state_d = S_CBZ;
          CLS_B:    state_d = S_BRANCH;
          CLS_HLT: begin
            state_d = S_HALT;
            err_d   = ERR_NONE;
          end
          default: begin
            state_d = S_HALT;
            err_d   = ERR_ILLEGAL;
          end
        endcase
      end
      S_EXEC_R: state_d = S_WB_R;
      S_WB_R: begin
        retire_s = 1'b1;
        state_d  = S_FETCH;
      end
      S_ADDR: begin
        // The instruction register still holds the memory opcode here.
        if (cls_s == CLS_LDUR) begin
          state_d = S_MEM_RD;
        end else if (cls_s == CLS_STUR) begin
          state_d = S_MEM_WR;
        end else begin
          state_d = S_HALT;
          err_d   = ERR_ILLEGAL;
        end
      end
      S_MEM_RD: begin
        if (bus.mem_ready) begin
          state_d = S_WB_MEM;
        end else if (mem_expire_s) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_WB_MEM: begin
        retire_s = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WR: begin
        if (bus.mem_ready) begin
          retire_s = 1'b1;
          state_d  = S_FETCH;
        end else if (mem_expire_s) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_CBZ: begin
        retire_s = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        retire_s = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: begin
        // Unused encodings are treated as corruption and stop the machine.
        state_d = S_HALT;
        err_d   = ERR_ILLEGAL;
      end
    endcase
  end

  // Retired-instruction counter, wrapping naturally at 2^CNT_W.
  always_comb begin
    if (retire_s) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // State and status registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      tmo_q   <= '0;
      err_q   <= ERR_NONE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  // Moore control decode; FETCH and CBZ carry the only input-gated strobes.
  // Reset forces every control low at once so no write can slip through.
  always_comb begin
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    pc_src_s     = 1'b0;
    iord_s       = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    reg_write_s  = 1'b0;
    reg2loc_s    = 1'b0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = ALUB_REG;
    alu_op_s     = ALUOP_ADD;
    mem_to_reg_s = 1'b0;
    halted_s     = 1'b0;
    if (reset) begin
      halted_s = 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          mem_read_s  = 1'b1;
          alu_src_b_s = ALUB_FOUR;
          ir_write_s  = bus.mem_ready;
          pc_write_s  = bus.mem_ready;
        end
        S_DECODE: begin
          alu_src_b_s = ALUB_IMM_SH2;
          reg2loc_s   = (cls_s == CLS_STUR) || (cls_s == CLS_CBZ);
        end
        S_EXEC_R: begin
          alu_src_a_s = 1'b1;
          alu_op_s    = ALUOP_RTYPE;
        end
        S_WB_R: reg_write_s = 1'b1;
        S_ADDR: begin
          alu_src_a_s = 1'b1;
          alu_src_b_s = ALUB_IMM;
        end
        S_MEM_RD: begin
          iord_s     = 1'b1;
          mem_read_s = 1'b1;
        end
        S_WB_MEM: begin
          reg_write_s  = 1'b1;
          mem_to_reg_s = 1'b1;
        end
        S_MEM_WR: begin
          iord_s      = 1'b1;
          mem_write_s = 1'b1;
          reg2loc_s   = 1'b1;
        end
        S_CBZ: begin
          reg2loc_s   = 1'b1;
          alu_src_a_s = 1'b1;
          alu_op_s    = ALUOP_PASSB;
          pc_src_s    = 1'b1;
          pc_write_s  = bus.zero;
        end
        S_BRANCH: begin
          pc_src_s   = 1'b1;
          pc_write_s = 1'b1;
        end
        S_HALT: halted_s = 1'b1;
        default: halted_s = 1'b0;
      endcase
    end
  end

  assign bus.ir_write      = ir_write_s;
  assign bus.pc_write      = pc_write_s;
  assign bus.pc_src        = pc_src_s;
  assign bus.iord          = iord_s;
  assign bus.mem_read      = mem_read_s;
  assign bus.mem_write     = mem_write_s;
  assign bus.reg_write     = reg_write_s;
  assign bus.reg2loc       = reg2loc_s;
  assign bus.alu_src_a     = alu_src_a_s;
  assign bus.alu_src_b     = alu_src_b_s;
  assign bus.alu_op        = alu_op_s;
  assign bus.mem_to_reg    = mem_to_reg_s;
  assign bus.halted        = halted_s;
  assign bus.error_code    = err_q;
  assign bus.retired_count = count_q;
  assign bus.state_out     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
// Directed bench: a table of per-cycle {inputs, expected state/controls/count}
// rows, followed by hand-written sequences for halt, timeout, mid-access reset
// and counter wrap. MEM_TIMEOUT=4 and CNT_W=4 keep the corner cases short.
// Control vector layout (17 bits, MSB first):
//   ir_write pc_write pc_src iord mem_read mem_write reg_write reg2loc
//   alu_src_a alu_src_b[1:0] alu_op[1:0] mem_to_reg halted error_code[1:0]
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  localparam logic [16:0] C_NONE    = 17'b0_0_0_0_0_0_0_0_0_00_00_0_0_00;
  localparam logic [16:0] C_F_RDY   = 17'b1_1_0_0_1_0_0_0_0_01_00_0_0_00;
  localparam logic [16:0] C_F_WAIT  = 17'b0_0_0_0_1_0_0_0_0_01_00_0_0_00;
  localparam logic [16:0] C_DEC     = 17'b0_0_0_0_0_0_0_0_0_11_00_0_0_00;
  localparam logic [16:0] C_DEC_R2L = 17'b0_0_0_0_0_0_0_1_0_11_00_0_0_00;
  localparam logic [16:0] C_EXEC    = 17'b0_0_0_0_0_0_0_0_1_00_10_0_0_00;
  localparam logic [16:0] C_WBR     = 17'b0_0_0_0_0_0_1_0_0_00_00_0_0_00;
  localparam logic [16:0] C_ADDR    = 17'b0_0_0_0_0_0_0_0_1_10_00_0_0_00;
  localparam logic [16:0] C_MRD     = 17'b0_0_0_1_1_0_0_0_0_00_00_0_0_00;
  localparam logic [16:0] C_WBM     = 17'b0_0_0_0_0_0_1_0_0_00_00_1_0_00;
  localparam logic [16:0] C_MWR     = 17'b0_0_0_1_0_1_0_1_0_00_00_0_0_00;
  localparam logic [16:0] C_CBZ1    = 17'b0_1_1_0_0_0_0_1_1_00_01_0_0_00;
  localparam logic [16:0] C_CBZ0    = 17'b0_0_1_0_0_0_0_1_1_00_01_0_0_00;
  localparam logic [16:0] C_BR      = 17'b0_1_1_0_0_0_0_0_0_00_00_0_0_00;
  localparam logic [16:0] C_HLT_OK  = 17'b0_0_0_0_0_0_0_0_0_00_00_0_1_00;
  localparam logic [16:0] C_HLT_ILL = 17'b0_0_0_0_0_0_0_0_0_00_00_0_1_01;
  localparam logic [16:0] C_HLT_TMO = 17'b0_0_0_0_0_0_0_0_0_00_00_0_1_10;

  localparam logic [10:0] O_ADD  = 11'b10001011000;
  localparam logic [10:0] O_SUB  = 11'b11001011000;
  localparam logic [10:0] O_AND  = 11'b10001010000;
  localparam logic [10:0] O_ORR  = 11'b10101010000;
  localparam logic [10:0] O_LDUR = 11'b11111000010;
  localparam logic [10:0] O_STUR = 11'b11111000000;
  localparam logic [10:0] O_CBZ  = 11'b10110100101;
  localparam logic [10:0] O_B    = 11'b00010110011;
  localparam logic [10:0] O_HLT  = 11'b11010100010;

  typedef struct {
    logic [10:0]      opcode;
    logic             zero;
    logic             ready;
    logic [3:0]       st;
    logic [16:0]      ctl;
    logic [CNT_W-1:0] ret;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t vecs[$];
  logic [16:0] ctl_s;

  always #5 clock = ~clock;

  multicycle_controller_if #(.CNT_W(CNT_W)) bus ();

  multicycle_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  assign ctl_s = {bus.ir_write, bus.pc_write, bus.pc_src, bus.iord, bus.mem_read,
                  bus.mem_write, bus.reg_write, bus.reg2loc, bus.alu_src_a,
                  bus.alu_src_b, bus.alu_op, bus.mem_to_reg, bus.halted,
                  bus.error_code};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_v(input logic [10:0] op, input logic z, input logic r,
                       input logic [3:0] st, input logic [16:0] c, input int ret);
    vec_t v;
    v.opcode = op; v.zero = z; v.ready = r; v.st = st; v.ctl = c;
    v.ret = CNT_W'(ret);
    vecs.push_back(v);
  endtask

  // Called at a falling edge: drive, settle, compare, then move past one rising edge.
  task automatic run_row(input string tag, input vec_t v);
    bus.opcode    = v.opcode;
    bus.zero      = v.zero;
    bus.mem_ready = v.ready;
    #2;
    chk({tag, ".state"}, 32'(bus.state_out), 32'(v.st));
    chk({tag, ".ctl"}, 32'(ctl_s), 32'(v.ctl));
    chk({tag, ".retired"}, 32'(bus.retired_count), 32'(v.ret));
    @(negedge clock);
  endtask

  task automatic row(input string tag, input logic [10:0] op, input logic z, input logic r,
                     input logic [3:0] st, input logic [16:0] c, input int ret);
    vec_t v;
    v.opcode = op; v.zero = z; v.ready = r; v.st = st; v.ctl = c;
    v.ret = CNT_W'(ret);
    run_row(tag, v);
  endtask

  // Reset with mem_ready high so FETCH's request would show if not suppressed.
  task automatic do_reset(input string tag);
    bus.opcode = 11'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    reset = 1'b1;
    #2;
    chk({tag, ".rst_ctl"}, 32'(ctl_s), 32'(C_NONE));
    chk({tag, ".rst_state"}, 32'(bus.state_out), 32'd0);
    chk({tag, ".rst_retired"}, 32'(bus.retired_count), 32'd0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.opcode = 11'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clock);
    do_reset("init");

    // ADD: 4 cycles
    add_v(O_ADD, 1'b0, 1'b1, 4'd0, C_F_RDY, 0);
    add_v(O_ADD, 1'b0, 1'b1, 4'd1, C_DEC, 0);
    add_v(O_ADD, 1'b0, 1'b1, 4'd2, C_EXEC, 0);
    add_v(O_ADD, 1'b0, 1'b1, 4'd3, C_WBR, 0);
    // LDUR with 3 wait cycles; ready arrives on the last permitted cycle
    add_v(O_LDUR, 1'b0, 1'b1, 4'd0, C_F_RDY, 1);
    add_v(O_LDUR, 1'b0, 1'b1, 4'd1, C_DEC, 1);
    add_v(O_LDUR, 1'b0, 1'b1, 4'd4, C_ADDR, 1);
    add_v(O_LDUR, 1'b0, 1'b0, 4'd5, C_MRD, 1);
    add_v(O_LDUR, 1'b0, 1'b0, 4'd5, C_MRD, 1);
    add_v(O_LDUR, 1'b0, 1'b0, 4'd5, C_MRD, 1);
    add_v(O_LDUR, 1'b0, 1'b1, 4'd5, C_MRD, 1);
    add_v(O_LDUR, 1'b0, 1'b1, 4'd6, C_WBM, 1);
    // STUR: 4 cycles
    add_v(O_STUR, 1'b0, 1'b1, 4'd0, C_F_RDY, 2);
    add_v(O_STUR, 1'b0, 1'b1, 4'd1, C_DEC_R2L, 2);
    add_v(O_STUR, 1'b0, 1'b1, 4'd4, C_ADDR, 2);
    add_v(O_STUR, 1'b0, 1'b1, 4'd7, C_MWR, 2);
    // CBZ taken, then not taken
    add_v(O_CBZ, 1'b1, 1'b1, 4'd0, C_F_RDY, 3);
    add_v(O_CBZ, 1'b1, 1'b1, 4'd1, C_DEC_R2L, 3);
    add_v(O_CBZ, 1'b1, 1'b1, 4'd8, C_CBZ1, 3);
    add_v(O_CBZ, 1'b0, 1'b1, 4'd0, C_F_RDY, 4);
    add_v(O_CBZ, 1'b0, 1'b1, 4'd1, C_DEC_R2L, 4);
    add_v(O_CBZ, 1'b0, 1'b1, 4'd8, C_CBZ0, 4);
    // B
    add_v(O_B, 1'b0, 1'b1, 4'd0, C_F_RDY, 5);
    add_v(O_B, 1'b0, 1'b1, 4'd1, C_DEC, 5);
    add_v(O_B, 1'b0, 1'b1, 4'd9, C_BR, 5);
    // SUB with a slow fetch; mem_ready ignored while in DECODE/EXEC
    add_v(O_SUB, 1'b0, 1'b0, 4'd0, C_F_WAIT, 6);
    add_v(O_SUB, 1'b0, 1'b1, 4'd0, C_F_RDY, 6);
    add_v(O_SUB, 1'b0, 1'b0, 4'd1, C_DEC, 6);
    add_v(O_SUB, 1'b0, 1'b0, 4'd2, C_EXEC, 6);
    add_v(O_SUB, 1'b0, 1'b0, 4'd3, C_WBR, 6);
    // AND, ORR
    add_v(O_AND, 1'b0, 1'b1, 4'd0, C_F_RDY, 7);
    add_v(O_AND, 1'b0, 1'b1, 4'd1, C_DEC, 7);
    add_v(O_AND, 1'b0, 1'b1, 4'd2, C_EXEC, 7);
    add_v(O_AND, 1'b0, 1'b1, 4'd3, C_WBR, 7);
    add_v(O_ORR, 1'b0, 1'b1, 4'd0, C_F_RDY, 8);
    add_v(O_ORR, 1'b0, 1'b1, 4'd1, C_DEC, 8);
    add_v(O_ORR, 1'b0, 1'b1, 4'd2, C_EXEC, 8);
    add_v(O_ORR, 1'b0, 1'b1, 4'd3, C_WBR, 8);
    // HLT: clean halt, no retire
    add_v(O_HLT, 1'b0, 1'b1, 4'd0, C_F_RDY, 9);
    add_v(O_HLT, 1'b0, 1'b1, 4'd1, C_DEC, 9);
    add_v(O_HLT, 1'b0, 1'b1, 4'd10, C_HLT_OK, 9);
    add_v(O_ADD, 1'b1, 1'b0, 4'd10, C_HLT_OK, 9);

    for (int i = 0; i < vecs.size(); i++) begin
      run_row($sformatf("row%0d", i), vecs[i]);
    end

    // Illegal opcode, then 20 cycles of random inputs while halted
    do_reset("ill");
    row("ill.fetch", 11'd0, 1'b0, 1'b1, 4'd0, C_F_RDY, 0);
    row("ill.dec", 11'd0, 1'b0, 1'b1, 4'd1, C_DEC, 0);
    for (int i = 0; i < 20; i++) begin
      row($sformatf("ill.hold%0d", i), 11'($urandom), 1'($urandom), 1'($urandom),
          4'd10, C_HLT_ILL, 0);
    end

    // Fetch timeout: four unanswered cycles, never loading the IR
    do_reset("tmo");
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      row($sformatf("tmo.wait%0d", i), O_ADD, 1'b0, 1'b0, 4'd0, C_F_WAIT, 0);
    end
    row("tmo.halt", O_ADD, 1'b0, 1'b1, 4'd10, C_HLT_TMO, 0);

    // Store timeout: MEM_WR waits out the limit without completing
    do_reset("stmo");
    row("stmo.fetch", O_STUR, 1'b0, 1'b1, 4'd0, C_F_RDY, 0);
    row("stmo.dec", O_STUR, 1'b0, 1'b1, 4'd1, C_DEC_R2L, 0);
    row("stmo.addr", O_STUR, 1'b0, 1'b1, 4'd4, C_ADDR, 0);
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      row($sformatf("stmo.wait%0d", i), O_STUR, 1'b0, 1'b0, 4'd7, C_MWR, 0);
    end
    row("stmo.halt", O_STUR, 1'b0, 1'b0, 4'd10, C_HLT_TMO, 0);

    // Reset in the middle of a store that is still waiting
    do_reset("mrst");
    row("mrst.bf", O_B, 1'b0, 1'b1, 4'd0, C_F_RDY, 0);
    row("mrst.bd", O_B, 1'b0, 1'b1, 4'd1, C_DEC, 0);
    row("mrst.bb", O_B, 1'b0, 1'b1, 4'd9, C_BR, 0);
    row("mrst.sf", O_STUR, 1'b0, 1'b1, 4'd0, C_F_RDY, 1);
    row("mrst.sd", O_STUR, 1'b0, 1'b1, 4'd1, C_DEC_R2L, 1);
    row("mrst.sa", O_STUR, 1'b0, 1'b1, 4'd4, C_ADDR, 1);
    bus.mem_ready = 1'b0;
    #2;
    chk("mrst.pre_mem_write", 32'(bus.mem_write), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("mrst.mem_write_drop", 32'(bus.mem_write), 32'd0);
    chk("mrst.ctl_drop", 32'(ctl_s), 32'(C_NONE));
    chk("mrst.state_drop", 32'(bus.state_out), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    row("mrst.refetch", O_ADD, 1'b0, 1'b0, 4'd0, C_F_WAIT, 0);

    // Counter wrap with CNT_W=4: sixteen branches return it to zero
    do_reset("wrap");
    for (int k = 0; k < 16; k++) begin
      row($sformatf("wrap%0d.f", k), O_B, 1'b0, 1'b1, 4'd0, C_F_RDY, k);
      row($sformatf("wrap%0d.d", k), O_B, 1'b0, 1'b1, 4'd1, C_DEC, k);
      row($sformatf("wrap%0d.b", k), O_B, 1'b0, 1'b1, 4'd9, C_BR, k);
    end
    row("wrap.final", O_ADD, 1'b0, 1'b0, 4'd0, C_F_WAIT, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
